power_load_array: RTL

- Parametrised, run-controlled power-load generator for FPGA power estimation.
- Instantiates N_CH independent single-port RAM channels. Each channel is driven by its own 16-bit LFSR and gated by per-channel power and write enables.
- Activity runs in a bounded window set by a cycle count, with a programmable duty cycle, so that measured power can be correlated with a known access rate.
- Sits under the top-level measurement harness and replaces the fixed 32-channel, always-on load.

---
 rtl/power_load_array.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/power_load_array.sv
// Run-controlled RAM power-load generator: N_CH LFSR-driven single-port RAMs with duty gating.
// Optional access counter enabled by defining POWER_LOAD_ACCESS_CNT_EN.
module power_load_array #(
    parameter int N_CH   = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clk100m,
    input  logic              rstn,
    input  logic              start,
    input  logic [31:0]       run_cycles,
    input  logic [4:0]        duty,
    input  logic [N_CH-1:0]   pwr_en_in,
    input  logic [N_CH-1:0]   opt_en_in,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   dummy_out,
    output logic [31:0]       access_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              run_start;
    logic [31:0]       remaining;
    logic [3:0]        phase;
    logic              active;
    logic [N_CH-1:0]   pwr_en_q;
    logic [N_CH-1:0]   opt_en_q;
    logic [N_CH-1:0]   ena;
    logic [N_CH-1:0]   wea;
    logic [N_CH-1:0]   douta_par;
    logic [15:0]       lfsr [N_CH];

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [4:0] duty_clip(input logic [4:0] d);
        return (d > 5'd16) ? 5'd16 : d;
    endfunction

    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (run_cycles == 32'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        run_start  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (remaining == 32'd1) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are decoded from the registered state, so they trail it by one cycle
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state == RUN);
            done  <= (state == DONE);
        end
    end

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            remaining <= 32'd0;
            phase     <= 4'd0;
        end else if (run_start) begin
            remaining <= run_cycles;
            phase     <= 4'd0;
        end else if (state == RUN) begin
            remaining <= remaining - 32'd1;
            phase     <= phase + 4'd1;
        end
    end

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) lfsr[i] <= 16'(i + 1);
        end else if (run_start) begin
            for (int i = 0; i < N_CH; i++) lfsr[i] <= 16'(i + 1);
        end else if (state == RUN) begin
            for (int i = 0; i < N_CH; i++) lfsr[i] <= lfsr_next(lfsr[i]);
        end
    end

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            pwr_en_q <= '0;
            opt_en_q <= '0;
        end else begin
            pwr_en_q <= pwr_en_in;
            opt_en_q <= opt_en_in;
        end
    end

    assign active = (state == RUN) && ({1'b0, phase} < duty_clip(duty));
    assign ena    = {N_CH{active}} & pwr_en_q;
    assign wea    = ena & opt_en_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dina;
        logic [DATA_W-1:0] douta;
        logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

        assign addr = lfsr[gi][ADDR_W-1:0];
        for (genvar k = 0; k < DATA_W; k++) begin : g_din
            assign dina[k] = lfsr[gi][(ADDR_W + k) % 16];
        end

        always_ff @(posedge clk100m) begin
            if (wea[gi]) mem[addr] <= dina;
        end

        // Read-first: the read samples the array before this edge's write lands
        always_ff @(posedge clk100m or negedge rstn) begin
            if (!rstn)        douta <= '0;
            else if (ena[gi]) douta <= mem[addr];
        end

        assign douta_par[gi] = ^douta;
    end

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) dummy_out <= '0;
        else       dummy_out <= douta_par;
    end

`ifdef POWER_LOAD_ACCESS_CNT_EN
    function automatic logic [6:0] popcount(input logic [N_CH-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int j = 0; j < N_CH; j++) c = c + {6'd0, v[j]};
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [6:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {26'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn)          access_count <= 32'd0;
        else if (run_start) access_count <= 32'd0;
        else                access_count <= sat_add(access_count, popcount(ena));
    end
`else
    assign access_count = 32'd0;
`endif

endmodule
